// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl: round-robin write sequencer for a bank of gated D-latch registers.
// Shares one latch-bank write port among NREQ requesters. For each write it drives D,
// pulses one latch enable for EN_CYCLES cycles, then holds D for one more cycle, so a
// latch never sees D move while its enable is high.
// Ports:
//   i_clk, i_rst_n  clock (rising edge) and asynchronous active-low reset
//   i_req           per-requester level request, held until its grant
//   i_req_addr      per-requester target register, slice i = [i*AW +: AW]
//   i_req_data      per-requester write data, slice i = [i*WIDTH +: WIDTH]
//   o_gnt           one-hot single-cycle pulse, write for requester i complete
//   o_latch_d       shared D bus to every latch in the bank
//   o_latch_en      one-hot latch enables, zero outside the enable phase
//   o_busy          high while a write sequence is in progress
module latch_bank_ctrl #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned NREG      = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EN_CYCLES = 1,
  localparam int unsigned AW       = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*AW-1:0]    i_req_addr,
  input  logic [NREQ*WIDTH-1:0] i_req_data,
  output logic [NREQ-1:0]       o_gnt,
  output logic [WIDTH-1:0]      o_latch_d,
  output logic [NREG-1:0]       o_latch_en,
  output logic                  o_busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ENABLE = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_sel;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_en_cnt;

  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_latch_d;
  logic [NREG-1:0]  r_latch_en;
  logic             r_busy;

  logic             w_found;
  logic [PW-1:0]    w_win;
  logic [AW-1:0]    w_cap_addr;
  logic [WIDTH-1:0] w_cap_data;
  logic [NREQ-1:0]  w_gnt_nxt;
  logic [WIDTH-1:0] w_latch_d_nxt;
  logic [NREG-1:0]  w_latch_en_nxt;
  logic             w_busy_nxt;

  // Round-robin pick: scan requesters starting at r_ptr, wrapping modulo NREQ
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!w_found && i_req[i] && (((32'(r_ptr) + k) % NREQ) == i)) begin
          w_found = 1'b1;
          w_win   = PW'(i);
        end
      end
    end
  end

  // Address/data slice of the winning requester
  always_comb begin
    w_cap_addr = '0;
    w_cap_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_win == PW'(i)) begin
        w_cap_addr = i_req_addr[i*AW +: AW];
        w_cap_data = i_req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state; IDLE ignores requests while the grant pulse is still visible so a
  // requester that drops REQ on seeing its grant is never granted twice
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_found && !(|r_gnt)) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ENABLE;
      S_ENABLE: if (r_en_cnt == CW'(EN_CYCLES - 1)) w_state_nxt = S_HOLD;
      S_HOLD:   w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Transaction capture, enable-width counter and round-robin pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr    <= '0;
      r_sel    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_en_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && w_state_nxt == S_SETUP) begin
        r_sel  <= w_win;
        r_addr <= w_cap_addr;
        r_data <= w_cap_data;
      end
      if (r_state == S_ENABLE) r_en_cnt <= r_en_cnt + CW'(1);
      else                     r_en_cnt <= '0;
      if (r_state == S_DONE) begin
        r_ptr <= (32'(r_sel) == NREQ - 1) ? '0 : PW'(32'(r_sel) + 1);
      end
    end
  end

  // Output decode from the current state; registered below
  always_comb begin
    w_gnt_nxt      = '0;
    w_latch_en_nxt = '0;
    w_latch_d_nxt  = r_latch_d;
    w_busy_nxt     = (r_state != S_IDLE);
    case (r_state)
      S_SETUP: w_latch_d_nxt = r_data;
      S_ENABLE: begin
        // Out-of-range addresses match no enable bit
        for (int unsigned i = 0; i < NREG; i++) begin
          if (32'(r_addr) == i) w_latch_en_nxt[i] = 1'b1;
        end
      end
      S_DONE: begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (32'(r_sel) == i) w_gnt_nxt[i] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gnt      <= '0;
      r_latch_d  <= '0;
      r_latch_en <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_gnt      <= w_gnt_nxt;
      r_latch_d  <= w_latch_d_nxt;
      r_latch_en <= w_latch_en_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign o_gnt      = r_gnt;
  assign o_latch_d  = r_latch_d;
  assign o_latch_en = r_latch_en;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// tb_latch_bank_ctrl: scoreboard bench for latch_bank_ctrl.
// Instance a: NREQ=2, NREG=4, EN_CYCLES=1. Instance b: NREQ=2, NREG=3, EN_CYCLES=3.
module tb_latch_bank_ctrl;

  typedef struct {
    int idx;     // requester expected to be granted
    int en_reg;  // latch expected to be enabled, -1 for none
    int data;    // value expected on D
    int en_w;    // enable width in cycles
    int lat;     // cycles from request to grant, -1 if unchecked
    int gap;     // cycles since previous grant, 0 if unchecked
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req      [2];
  logic [3:0]  req_addr [2];
  logic [15:0] req_data [2];
  logic [1:0]  gnt      [2];
  logic [7:0]  ld       [2];
  logic        busy     [2];
  logic [3:0]  en_a;
  logic [2:0]  en_b;

  exp_t q0[$];
  exp_t q1[$];
  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int nreg  [2] = '{4, 3};
  int encyc [2] = '{1, 3};
  int ptr [2];
  int prev_en [2];
  int prev_d [2];
  int en_w [2];
  int en_seen [2];
  int last_gnt [2];
  int req_cyc [2];
  int lm [2][4];
  int exp_reg [2][4];

  latch_bank_ctrl #(.NREQ(2), .NREG(4), .WIDTH(8), .EN_CYCLES(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req[0]), .i_req_addr(req_addr[0]),
    .i_req_data(req_data[0]), .o_gnt(gnt[0]), .o_latch_d(ld[0]),
    .o_latch_en(en_a), .o_busy(busy[0]));

  latch_bank_ctrl #(.NREQ(2), .NREG(3), .WIDTH(8), .EN_CYCLES(3)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req[1]), .i_req_addr(req_addr[1]),
    .i_req_data(req_data[1]), .o_gnt(gnt[1]), .o_latch_d(ld[1]),
    .o_latch_en(en_b), .o_busy(busy[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function void chk(input string nm, input int id, input int act, input int ex);
    nchk++;
    if (act != ex) begin
      nerr++;
      $display("FAIL %s dut%0d: got %0d (0x%0h) expected %0d (0x%0h)", nm, id, act, act, ex, ex);
    end
  endfunction

  function void fail_timeout(input string nm, input int id);
    nchk++;
    nerr++;
    $display("FAIL %s dut%0d: no response within cycle budget", nm, id);
  endfunction

  function void push(input int id, input exp_t x);
    if (id == 0) q0.push_back(x);
    else         q1.push_back(x);
  endfunction

  // Monitor: tracks enable pulses into a latch model and checks each grant
  function void mon(input int id, input logic [1:0] g, input logic [3:0] e,
                    input logic [7:0] d, input logic b);
    exp_t x;
    int   idx;
    if (!rst_n) begin
      prev_en[id] = 0;
      en_w[id]    = 0;
      en_seen[id] = -1;
      prev_d[id]  = int'(d);
      return;
    end
    if (e != 4'd0) begin
      chk("en_onehot", id, $countones(e), 1);
      idx = 0;
      for (int i = 0; i < 4; i++) if (e[i]) idx = i;
      if (prev_en[id] == 0) en_seen[id] = idx;
      else chk("en_same_reg", id, idx, en_seen[id]);
      en_w[id]++;
      lm[id][idx] = int'(d);
    end
    if (e != 4'd0 || prev_en[id] != 0) chk("d_stable_around_en", id, int'(d), prev_d[id]);
    if (g != 2'd0) begin
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_gnt dut%0d: got gnt=%b with nothing outstanding", id, g);
      end else begin
        if (id == 0) x = q0.pop_front();
        else         x = q1.pop_front();
        chk("gnt_idx", id, int'(g), 1 << x.idx);
        chk("en_target", id, en_seen[id], x.en_reg);
        chk("en_width", id, en_w[id], x.en_w);
        chk("d_at_gnt", id, int'(d), x.data);
        chk("busy_at_gnt", id, int'(b), 1);
        if (x.lat >= 0) chk("latency", id, cyc - req_cyc[id], x.lat);
        if (x.gap > 0)  chk("grant_gap", id, cyc - last_gnt[id], x.gap);
      end
      last_gnt[id] = cyc;
      en_w[id]     = 0;
      en_seen[id]  = -1;
    end
    prev_en[id] = int'(e);
    prev_d[id]  = int'(d);
  endfunction

  always @(negedge clk) begin
    mon(0, gnt[0], en_a, ld[0], busy[0]);
    mon(1, gnt[1], {1'b0, en_b}, ld[1], busy[1]);
  end

  // All requesters in mask raise REQ together from idle; each drops on its grant
  task automatic run_phase(input int id, input logic [1:0] mask,
                           input logic [3:0] addr, input logic [15:0] data);
    exp_t x;
    logic [1:0] pend;
    int j, a, pos, last, t;
    pend = mask;
    pos  = 0;
    last = 0;
    while (pend != 2'b00) begin
      j = pend[ptr[id]] ? ptr[id] : 1 - ptr[id];
      a = int'(addr[j*2 +: 2]);
      x.idx    = j;
      x.en_reg = (a < nreg[id]) ? a : -1;
      x.data   = int'(data[j*8 +: 8]);
      x.en_w   = (a < nreg[id]) ? encyc[id] : 0;
      x.lat    = (4 + encyc[id]) + pos * (5 + encyc[id]);
      x.gap    = (pos == 0) ? 0 : 5 + encyc[id];
      push(id, x);
      if (x.en_reg >= 0) exp_reg[id][a] = x.data;
      ptr[id] = (j + 1) % 2;
      pend[j] = 1'b0;
      pos++;
      last = x.data;
    end
    @(negedge clk);
    req_addr[id] = addr;
    req_data[id] = data;
    req[id]      = mask;
    req_cyc[id]  = cyc;
    t = 0;
    while (req[id] != 2'b00 && t < 80) begin
      @(negedge clk);
      req[id] = req[id] & ~gnt[id];
      t++;
    end
    if (req[id] != 2'b00) begin
      fail_timeout("phase_grant", id);
      req[id] = 2'b00;
    end
    repeat (2) @(negedge clk);
    chk("latch_d_idle", id, int'(ld[id]), last);
  endtask

  // Both requesters hold REQ continuously for n grants
  task automatic run_hold(input int id, input logic [3:0] addr,
                          input logic [15:0] data, input int n);
    exp_t x;
    int j, a, got, t;
    j = ptr[id];
    for (int k = 0; k < n; k++) begin
      a = int'(addr[j*2 +: 2]);
      x.idx    = j;
      x.en_reg = (a < nreg[id]) ? a : -1;
      x.data   = int'(data[j*8 +: 8]);
      x.en_w   = (a < nreg[id]) ? encyc[id] : 0;
      x.lat    = (k == 0) ? 4 + encyc[id] : -1;
      x.gap    = (k == 0) ? 0 : 5 + encyc[id];
      push(id, x);
      if (x.en_reg >= 0) exp_reg[id][a] = x.data;
      j = (j + 1) % 2;
    end
    ptr[id] = j;
    @(negedge clk);
    req_addr[id] = addr;
    req_data[id] = data;
    req[id]      = 2'b11;
    req_cyc[id]  = cyc;
    got = 0;
    t   = 0;
    while (got < n && t < 200) begin
      @(negedge clk);
      t++;
      if (gnt[id] != 2'b00) got++;
    end
    req[id] = 2'b00;
    if (got < n) fail_timeout("hold_grants", id);
    repeat (2) @(negedge clk);
  endtask

  // Data/address change and REQ drop while the enable is high
  task automatic mid_txn();
    exp_t x;
    int t;
    x.idx = 0; x.en_reg = 2; x.data = 8'hA5; x.en_w = 1; x.lat = 5; x.gap = 0;
    push(0, x);
    exp_reg[0][2] = 8'hA5;
    ptr[0] = 1;
    @(negedge clk);
    req_addr[0] = {2'd0, 2'd2};
    req_data[0] = {8'h00, 8'hA5};
    req[0]      = 2'b01;
    req_cyc[0]  = cyc;
    t = 0;
    while (en_a == 4'd0 && t < 20) begin @(negedge clk); t++; end
    if (en_a == 4'd0) fail_timeout("mid_txn_en", 0);
    req_data[0] = {8'h00, 8'hFF};
    req_addr[0] = {2'd0, 2'd1};
    req[0]      = 2'b00;
    t = 0;
    while (gnt[0][0] == 1'b0 && t < 20) begin @(negedge clk); t++; end
    if (gnt[0][0] == 1'b0) fail_timeout("mid_txn_gnt", 0);
    repeat (2) @(negedge clk);
    chk("mid_txn_d_held", 0, int'(ld[0]), 8'hA5);
    chk("mid_txn_reg2", 0, lm[0][2], 8'hA5);
    chk("mid_txn_reg1_untouched", 0, lm[0][1], exp_reg[0][1]);
  endtask

  // Reset asserted while the enable is high
  task automatic mid_en_reset();
    int t;
    @(negedge clk);
    req_addr[0] = {2'd0, 2'd1};
    req_data[0] = {8'h00, 8'h77};
    req[0]      = 2'b01;
    t = 0;
    while (en_a == 4'd0 && t < 20) begin @(negedge clk); t++; end
    if (en_a == 4'd0) fail_timeout("abort_en", 0);
    rst_n = 1'b0;
    #1;
    chk("abort_en_drop", 0, int'(en_a), 0);
    chk("abort_busy", 0, int'(busy[0]), 0);
    chk("abort_d", 0, int'(ld[0]), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_gnt", 0, int'(gnt[0]), 0);
    end
    req[0] = 2'b00;
    exp_reg[0][1] = -1;
    ptr[0] = 0;
    ptr[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int id = 0; id < 2; id++) begin
      req[id] = 2'b00;
      req_addr[id] = 4'd0;
      req_data[id] = 16'd0;
      ptr[id] = 0;
      last_gnt[id] = 0;
      req_cyc[id] = 0;
      for (int r = 0; r < 4; r++) begin
        lm[id][r] = -1;
        exp_reg[id][r] = -1;
      end
    end

    // Reset held while requests toggle
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req[0] = 2'($urandom);
      req[1] = 2'($urandom);
      #1;
      for (int id = 0; id < 2; id++) begin
        chk("rst_gnt", id, int'(gnt[id]), 0);
        chk("rst_d", id, int'(ld[id]), 0);
        chk("rst_busy", id, int'(busy[id]), 0);
      end
      chk("rst_en", 0, int'(en_a), 0);
      chk("rst_en", 1, int'(en_b), 0);
    end
    @(negedge clk);
    req[0] = 2'b00;
    req[1] = 2'b00;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);

    // Single write
    run_phase(0, 2'b01, {2'd0, 2'd2}, {8'h00, 8'hA5});
    chk("single_reg2", 0, lm[0][2], 8'hA5);

    // Contention with both requests held
    run_hold(0, {2'd3, 2'd1}, {8'h33, 8'h11}, 4);
    chk("contention_reg1", 0, lm[0][1], 8'h11);
    chk("contention_reg3", 0, lm[0][3], 8'h33);

    // Inputs changing mid-transaction
    mid_txn();

    // Wide enable and out-of-range address
    run_phase(1, 2'b01, {2'd0, 2'd3}, {8'h00, 8'h5C});
    run_phase(1, 2'b01, {2'd0, 2'd0}, {8'h00, 8'hC3});
    chk("wide_en_reg0", 1, lm[1][0], 8'hC3);

    // Reset during enable, then requester 0 must win first again
    mid_en_reset();
    run_phase(0, 2'b11, {2'd2, 2'd0}, {8'h2B, 8'h0A});

    // Randomized phases on both instances
    for (int n = 0; n < 24; n++) begin
      run_phase((n % 3 == 2) ? 1 : 0, 2'($urandom_range(1, 3)), 4'($urandom), 16'($urandom));
    end

    for (int id = 0; id < 2; id++) begin
      for (int r = 0; r < nreg[id]; r++) begin
        if (exp_reg[id][r] >= 0) chk("latch_final", id, lm[id][r], exp_reg[id][r]);
      end
    end
    chk("queue_drained", 0, q0.size(), 0);
    chk("queue_drained", 1, q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
